// File: rtl/video_mode_pkg.sv
// Shared definitions for the video mode controller and the mux top-level.
//   vmc_state_t : controller FSM states
//   MODE_*      : 2-bit mux `bg` select encodings
package video_mode_pkg;

  typedef enum logic [1:0] {IDLE, PENDING, LOCKOUT} vmc_state_t;

  localparam logic [1:0] MODE_CAMERA    = 2'b00;
  localparam logic [1:0] MODE_CH_MASK   = 2'b01;
  localparam logic [1:0] MODE_THR_MASK  = 2'b10;
  localparam logic [1:0] MODE_Y_MAGENTA = 2'b11;

endpackage

// File: rtl/rising_edge_det.sv
// Rising-edge detector: registers the previous input level and flags d & ~q.
//   clk  : clock
//   rst  : asynchronous active-high reset (previous level forced to RESET_VAL)
//   d    : input level, synchronous to clk
//   rise : combinational, high in the cycle d goes 0 -> 1
module rising_edge_det #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RESET_VAL;
    else     q <= d;
  end

  assign rise = d & ~q;

endmodule

// File: rtl/video_mode_ctrl.sv
// Frame-synchronous mode select controller for the pixel-output mux.
// Requests (button edge, external valid/ready, auto-cycle timer) only take
// effect on a vsync rising edge, so a frame never mixes two modes.
//   clk_in, rst_in    : pixel clock, async active-high reset
//   vsync_in          : vsync level from the timing generator
//   btn_in            : debounced button; rising edge requests next mode
//   auto_en_in        : enables auto-cycling every FRAMES_PER_MODE frames
//   ext_valid_in/ext_mode_in/ext_ready_out : external mode request handshake
//   bg_out            : committed mode (mux select)
//   pending_out       : a request is waiting for a frame boundary
//   mode_changed_out  : one-cycle pulse after each commit
module video_mode_ctrl
  import video_mode_pkg::*;
#(
  parameter logic [1:0]  RESET_MODE      = MODE_CAMERA,
  parameter int unsigned FRAMES_PER_MODE = 120,
  parameter int unsigned LOCKOUT_FRAMES  = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       vsync_in,
  input  logic       btn_in,
  input  logic       auto_en_in,
  input  logic       ext_valid_in,
  input  logic [1:0] ext_mode_in,
  output logic       ext_ready_out,
  output logic [1:0] bg_out,
  output logic       pending_out,
  output logic       mode_changed_out
);

  localparam logic [11:0] AUTO_LAST   = 12'(FRAMES_PER_MODE - 1);
  localparam logic [7:0]  LOCK_RELOAD = (LOCKOUT_FRAMES == 0) ? 8'd0
                                                              : 8'(LOCKOUT_FRAMES - 1);

  vmc_state_t  state_q, state_d;
  logic [1:0]  bg_q, bg_d;
  logic [1:0]  pending_q, pending_d;
  logic [11:0] auto_cnt, auto_d;
  logic [7:0]  lock_cnt, lock_d;
  logic        changed_q;

  logic        fe, be, ext_acc, req, commit;
  logic [1:0]  base_mode, req_mode, commit_mode;

  // Previous levels reset high so a level already high at reset release is not an edge.
  rising_edge_det #(.RESET_VAL(1'b1)) u_vsync_edge (
    .clk  (clk_in),
    .rst  (rst_in),
    .d    (vsync_in),
    .rise (fe)
  );

  rising_edge_det #(.RESET_VAL(1'b1)) u_btn_edge (
    .clk  (clk_in),
    .rst  (rst_in),
    .d    (btn_in),
    .rise (be)
  );

  assign ext_ready_out = (state_q != LOCKOUT);
  assign pending_out   = (state_q == PENDING);
  assign ext_acc       = ext_valid_in & ext_ready_out;
  // External request wins over a coincident button edge; both are refused in lockout.
  assign req           = ext_acc | (be & ext_ready_out);
  assign base_mode     = (state_q == PENDING) ? pending_q : bg_q;
  assign req_mode      = ext_acc ? ext_mode_in : base_mode + 2'd1;

  always_comb begin
    state_d     = state_q;
    bg_d        = bg_q;
    pending_d   = pending_q;
    auto_d      = auto_cnt;
    lock_d      = lock_cnt;
    commit      = 1'b0;
    commit_mode = bg_q;

    case (state_q)
      IDLE: begin
        // A request seen on a frame edge still waits for the next one.
        if (req) begin
          pending_d = req_mode;
          auto_d    = '0;
          state_d   = PENDING;
        end else if (!auto_en_in) begin
          auto_d = '0;
        end else if (fe) begin
          if (auto_cnt == AUTO_LAST) begin
            commit      = 1'b1;
            commit_mode = bg_q + 2'd1;
            auto_d      = '0;
          end else begin
            auto_d = auto_cnt + 12'd1;
          end
        end
      end
      PENDING: begin
        if (fe) begin
          commit      = 1'b1;
          commit_mode = req ? req_mode : pending_q;
        end else if (req) begin
          pending_d = req_mode;
        end
      end
      LOCKOUT: begin
        if (fe) begin
          if (lock_cnt == '0) state_d = IDLE;
          else                lock_d  = lock_cnt - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (commit) begin
      bg_d = commit_mode;
      if (LOCKOUT_FRAMES > 0) begin
        state_d = LOCKOUT;
        lock_d  = LOCK_RELOAD;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      bg_q      <= RESET_MODE;
      pending_q <= RESET_MODE;
      auto_cnt  <= '0;
      lock_cnt  <= '0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bg_q      <= bg_d;
      pending_q <= pending_d;
      auto_cnt  <= auto_d;
      lock_cnt  <= lock_d;
      changed_q <= commit;
    end
  end

  assign bg_out           = bg_q;
  assign mode_changed_out = changed_q;

endmodule
